gb_lcd_capture: RTL and testbench

- Receiving end of the PPU pixel stream: accepts 2-bit pixels (px_in/px_valid) plus PPU mode and tracks the x/y raster position.
- Packs 8 pixels into a 16-bit word and writes words to an external framebuffer through a waitrequest-style write master. The framebuffer is read out to the display by the Qsys video path.
- A small word FIFO decouples the steady pixel rate from framebuffer stalls.

---
 rtl/gb_lcd_pkg.sv | 21 ++
 rtl/gb_lcd_word_fifo.sv | 67 ++++++
 rtl/gb_lcd_capture.sv | 196 +++++++++++++++++++
 tb/tb_gb_lcd_capture.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_lcd_pkg.sv
// Shared types for the LCD capture path: PPU mode encoding (also used by the PPU)
// and the capture state machine states.
package gb_lcd_pkg;

  localparam int LCD_W_DEFAULT = 160;
  localparam int LCD_H_DEFAULT = 144;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } ppu_mode_e;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    FRAME_END  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/gb_lcd_word_fifo.sv
// Synchronous word FIFO between pixel packing and the framebuffer write master.
// A push while full is accepted only if a pop happens in the same cycle.
module gb_lcd_word_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [W-1:0] head_next,
  output logic         full,
  output logic         empty,
  output logic         more_than_one
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full          = (cnt_q == CW'(DEPTH));
  assign empty         = (cnt_q == '0);
  assign more_than_one = (cnt_q > CW'(1));
  assign head          = mem_q[rd_ptr_q];
  assign head_next     = mem_q[rd_ptr_q + PW'(1)];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/gb_lcd_capture.sv
// PPU pixel stream capture: packs 2-bit pixels into 16-bit words and writes them to
// the framebuffer. Optional palette remap with GB_LCD_PALETTE_EN.
module gb_lcd_capture
  import gb_lcd_pkg::*;
#(
  parameter int LCD_W      = LCD_W_DEFAULT,
  parameter int LCD_H      = LCD_H_DEFAULT,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        px_in,
  input  logic              px_valid,
  input  logic [1:0]        ppu_mode,
  input  logic [7:0]        bgp,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [15:0]       fb_wdata,
  output logic              fb_wr,
  input  logic              fb_waitrequest,
  output logic              frame_done,
  output logic [7:0]        line_count,
  output logic              overflow
);

  localparam int                FW      = ADDR_W + 16;
  localparam logic [7:0]        LCD_W_L = 8'(LCD_W);
  localparam logic [7:0]        LCD_H_L = 8'(LCD_H);
  localparam logic [ADDR_W-1:0] WPL     = ADDR_W'(LCD_W / 8);

  cap_state_e        state_q, state_d;
  ppu_mode_e         mode_in, prev_mode_q;
  logic [7:0]        x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [15:0]       pack_q, pack_d;
  logic              push_q, push_d;
  logic [FW-1:0]     push_data_q, push_data_d;
  logic              fb_wr_q, fb_wr_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [15:0]       fb_wdata_q, fb_wdata_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;

  logic [1:0]        shade;
  logic              accept, line_end, vblank_start, fb_pop;
  logic [15:0]       packed_w, padded_w;
  logic [3:0]        fill_n;
  logic [ADDR_W-1:0] word_addr;
  logic [FW-1:0]     fifo_head, fifo_head_next;
  logic              fifo_full, fifo_empty, fifo_more;

  assign mode_in = ppu_mode_e'(ppu_mode);

`ifdef GB_LCD_PALETTE_EN
  assign shade = bgp[{px_in, 1'b0} +: 2];
`else
  logic unused_bgp;
  assign unused_bgp = ^bgp;
  assign shade      = px_in;
`endif

  gb_lcd_word_fifo #(.DEPTH(FIFO_DEPTH), .W(FW)) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (push_q),
    .push_data     (push_data_q),
    .pop           (fb_pop),
    .head          (fifo_head),
    .head_next     (fifo_head_next),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .more_than_one (fifo_more)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    line_base_d  = line_base_q;
    pack_d       = pack_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    frame_done_d = 1'b0;
    accept       = 1'b0;
    line_end     = (prev_mode_q == DRAW) && (mode_in == H_BLANK);
    vblank_start = (prev_mode_q != V_BLANK) && (mode_in == V_BLANK);

    case (state_q)
      WAIT_FRAME: begin
        if (px_valid && mode_in == DRAW) begin
          accept  = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        accept = px_valid && (x_q < LCD_W_L) && (y_q < LCD_H_L);
        if (vblank_start) state_d = FRAME_END;
      end
      FRAME_END: begin
        if (fifo_empty && !fb_wr_q && !push_q) begin
          frame_done_d = 1'b1;
          x_d          = '0;
          y_d          = '0;
          line_base_d  = '0;
          state_d      = WAIT_FRAME;
        end
      end
      default: state_d = WAIT_FRAME;
    endcase

    packed_w  = accept ? {pack_q[13:0], shade} : pack_q;
    fill_n    = {1'b0, x_q[2:0]} + {3'b000, accept};
    padded_w  = packed_w << {4'd8 - fill_n, 1'b0};
    word_addr = line_base_q + ADDR_W'(x_q[7:3]);

    if (accept) begin
      pack_d = packed_w;
      x_d    = x_q + 8'd1;
    end

    // A line end that coincides with the 8th pixel pushes only the full word.
    if (accept && x_q[2:0] == 3'd7) begin
      push_d      = 1'b1;
      push_data_d = {word_addr, packed_w};
    end else if (state_q == ACTIVE && line_end && fill_n != 4'd0) begin
      push_d      = 1'b1;
      push_data_d = {word_addr, padded_w};
    end

    if (state_q == ACTIVE && line_end) begin
      x_d = '0;
      if (y_q < LCD_H_L) begin
        y_d         = y_q + 8'd1;
        line_base_d = line_base_q + WPL;
      end
    end
  end

  // The outstanding write stays at the FIFO head until it completes.
  always_comb begin
    fb_pop     = fb_wr_q && !fb_waitrequest;
    fb_wr_d    = fb_wr_q;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    if (!fb_wr_q) begin
      if (!fifo_empty) begin
        fb_wr_d                 = 1'b1;
        {fb_addr_d, fb_wdata_d} = fifo_head;
      end
    end else if (!fb_waitrequest) begin
      fb_wr_d = fifo_more;
      if (fifo_more) {fb_addr_d, fb_wdata_d} = fifo_head_next;
    end
    overflow_d = overflow_q || (push_q && fifo_full && !fb_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_FRAME;
      prev_mode_q  <= H_BLANK;
      x_q          <= '0;
      y_q          <= '0;
      line_base_q  <= '0;
      pack_q       <= '0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      fb_wr_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_mode_q  <= mode_in;
      x_q          <= x_d;
      y_q          <= y_d;
      line_base_q  <= line_base_d;
      pack_q       <= pack_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      fb_wr_q      <= fb_wr_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign fb_wr      = fb_wr_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign frame_done = frame_done_q;
  assign line_count = y_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Directed bench for gb_lcd_capture: line packing, padding, stalls, overflow,
// full frame, reset mid-write and palette remap.
module tb_gb_lcd_capture;
  import gb_lcd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  px_in;
  logic        px_valid;
  logic [1:0]  ppu_mode;
  logic [7:0]  bgp;
  logic [11:0] fb_addr;
  logic [15:0] fb_wdata;
  logic        fb_wr;
  logic        fb_waitrequest;
  logic        frame_done;
  logic [7:0]  line_count;
  logic        overflow;

  gb_lcd_capture dut (
    .clk            (clk),
    .rst            (rst),
    .px_in          (px_in),
    .px_valid       (px_valid),
    .ppu_mode       (ppu_mode),
    .bgp            (bgp),
    .fb_addr        (fb_addr),
    .fb_wdata       (fb_wdata),
    .fb_wr          (fb_wr),
    .fb_waitrequest (fb_waitrequest),
    .frame_done     (frame_done),
    .line_count     (line_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t  act_q[$];
  int   rise_q[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic prev_wr = 1'b0;

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (fb_wr && !fb_waitrequest) act_q.push_back(wr_t'{fb_addr, fb_wdata, cyc_cnt});
    if (fb_wr && !prev_wr) rise_q.push_back(cyc_cnt);
    prev_wr = fb_wr;
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc_cnt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // v<4: constant pixel value; v==4: i%4; v==5: 3-i%4
  task automatic send_line(input int n, input int v);
    ppu_mode = DRAW;
    for (int i = 0; i < n; i++) begin
      px_valid = 1'b1;
      px_in    = (v == 4) ? 2'(i % 4) : (v == 5) ? 2'(3 - i % 4) : 2'(v);
      cyc(1);
    end
    px_valid = 1'b0;
    ppu_mode = H_BLANK;
    cyc(1);
  endtask

  task automatic wait_writes(input int n, input string tag);
    int b = 0;
    while (act_q.size() < n && b < 2000) begin
      cyc(1);
      b++;
    end
    cyc(5);
    chk(tag, act_q.size(), n);
  endtask

  task automatic end_frame(input string tag);
    int d0 = done_cnt;
    int b = 0;
    ppu_mode = V_BLANK;
    while (done_cnt == d0 && b < 2000) begin
      cyc(1);
      b++;
    end
    cyc(3);
    chk({tag, "_pulses"}, done_cnt - d0, 1);
    chk({tag, "_line_count"}, line_count, 0);
  endtask

  initial begin
    int px8_cyc;
    rst = 1'b1;
    px_in = 2'd0;
    px_valid = 1'b0;
    ppu_mode = H_BLANK;
    bgp = 8'hE4;
    fb_waitrequest = 1'b0;
    cyc(3);
    chk("rst_fb_wr", fb_wr, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_wdata", fb_wdata, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_line_count", line_count, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    cyc(2);

    // full line 0,1,2,3 repeated
    act_q.delete();
    rise_q.delete();
    px8_cyc = 0;
    ppu_mode = DRAW;
    for (int i = 0; i < 160; i++) begin
      px_valid = 1'b1;
      px_in = 2'(i % 4);
      if (i == 7) px8_cyc = cyc_cnt + 1;
      cyc(1);
    end
    px_valid = 1'b0;
    ppu_mode = H_BLANK;
    cyc(1);
    chk("t1_line_count", line_count, 1);
    wait_writes(20, "t1_nwrites");
    for (int i = 0; i < act_q.size(); i++) begin
      chk($sformatf("t1_addr%0d", i), act_q[i].addr, i);
      chk($sformatf("t1_data%0d", i), act_q[i].data, 16'h1B1B);
    end
    chk("t1_rise_seen", rise_q.size() > 0, 1);
    if (rise_q.size() > 0) chk("t1_latency", rise_q[0] - px8_cyc, 2);
    end_frame("t1_frame");

    // 13 pixels then line end: one full and one padded word
    act_q.delete();
    send_line(13, 3);
    chk("t2_line_count", line_count, 1);
    wait_writes(2, "t2_nwrites");
    if (act_q.size() >= 2) begin
      chk("t2_addr0", act_q[0].addr, 0);
      chk("t2_data0", act_q[0].data, 16'hFFFF);
      chk("t2_addr1", act_q[1].addr, 1);
      chk("t2_data1", act_q[1].data, 16'hFFC0);
    end
    end_frame("t2_frame");

    // 20-cycle stall at the start of a line
    act_q.delete();
    fb_waitrequest = 1'b1;
    ppu_mode = DRAW;
    for (int i = 0; i < 160; i++) begin
      if (i == 20) fb_waitrequest = 1'b0;
      if (i == 12) begin
        chk("t3_wr_12", fb_wr, 1);
        chk("t3_addr_12", fb_addr, 0);
        chk("t3_data_12", fb_wdata, 16'hE4E4);
      end
      if (i == 19) begin
        chk("t3_wr_19", fb_wr, 1);
        chk("t3_addr_19", fb_addr, 0);
        chk("t3_data_19", fb_wdata, 16'hE4E4);
      end
      px_valid = 1'b1;
      px_in = 2'(3 - i % 4);
      cyc(1);
    end
    px_valid = 1'b0;
    ppu_mode = H_BLANK;
    cyc(1);
    wait_writes(20, "t3_nwrites");
    for (int i = 0; i < act_q.size(); i++) begin
      chk($sformatf("t3_addr%0d", i), act_q[i].addr, i);
      chk($sformatf("t3_data%0d", i), act_q[i].data, 16'hE4E4);
    end
    chk("t3_overflow", overflow, 0);
    end_frame("t3_frame");

    // 100-cycle stall: words 8..11 lost
    act_q.delete();
    fb_waitrequest = 1'b1;
    ppu_mode = DRAW;
    for (int i = 0; i < 160; i++) begin
      if (i == 100) fb_waitrequest = 1'b0;
      if (i == 60) chk("t4_overflow_early", overflow, 0);
      if (i == 80) chk("t4_overflow_set", overflow, 1);
      px_valid = 1'b1;
      px_in = 2'd2;
      cyc(1);
    end
    px_valid = 1'b0;
    ppu_mode = H_BLANK;
    cyc(1);
    wait_writes(16, "t4_nwrites");
    for (int i = 0; i < act_q.size(); i++) begin
      chk($sformatf("t4_addr%0d", i), act_q[i].addr, (i < 8) ? i : i + 4);
      chk($sformatf("t4_data%0d", i), act_q[i].data, 16'hAAAA);
    end
    chk("t4_overflow_sticky", overflow, 1);
    end_frame("t4_frame");

    // palette remap with bgp=1B and zero pixels
    act_q.delete();
    bgp = 8'h1B;
    send_line(8, 0);
    wait_writes(1, "tp_nwrites");
`ifdef GB_LCD_PALETTE_EN
    if (act_q.size() > 0) chk("tp_data", act_q[0].data, 16'hFFFF);
`else
    if (act_q.size() > 0) chk("tp_data", act_q[0].data, 16'h0000);
`endif
    bgp = 8'hE4;
    end_frame("tp_frame");

    // full frame of 144 lines
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk("t5_overflow_cleared", overflow, 0);
    act_q.delete();
    for (int y = 0; y < 144; y++) send_line(160, 4);
    chk("t5_line_count", line_count, 144);
    end_frame("t5_frame");
    chk("t5_nwrites", act_q.size(), 2880);
    for (int i = 0; i < act_q.size(); i++) chk($sformatf("t5_addr%0d", i), act_q[i].addr, i);
    if (act_q.size() > 0) begin
      chk("t5_last_addr", act_q[act_q.size() - 1].addr, 2879);
      chk("t5_done_after_last", done_cyc > act_q[act_q.size() - 1].cyc, 1);
    end

    // reset during a stalled write
    act_q.delete();
    fb_waitrequest = 1'b1;
    send_line(10, 1);
    cyc(2);
    chk("t6_stalled_wr", fb_wr, 1);
    rst = 1'b1;
    cyc(1);
    chk("t6_wr_dropped", fb_wr, 0);
    rst = 1'b0;
    fb_waitrequest = 1'b0;
    cyc(2);
    chk("t6_no_write", act_q.size(), 0);
    send_line(8, 2);
    wait_writes(1, "t6_nwrites");
    if (act_q.size() > 0) begin
      chk("t6_addr", act_q[0].addr, 0);
      chk("t6_data", act_q[0].data, 16'hAAAA);
    end
    end_frame("t6_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
